// File: rtl/bit_clmul_multi_if.sv
// Handshake and operand bundle for the multi-cycle carry-less multiplier.
interface bit_clmul_multi_if #(
   parameter int XLEN = 32
);
   logic            enable;
   logic [1:0]      op;
   logic [XLEN-1:0] rdata1;
   logic [XLEN-1:0] rdata2;
   logic            clear;
   logic            busy;
   logic            ready;
   logic [XLEN-1:0] result;

   modport master (
      output enable, op, rdata1, rdata2, clear,
      input  busy, ready, result
   );

   modport slave (
      input  enable, op, rdata1, rdata2, clear,
      output busy, ready, result
   );
endinterface

// File: rtl/bit_clmul_multi.sv
// Multi-cycle clmul/clmulh/clmulr, STEP multiplier bits per cycle.
// Define BIT_CLMUL_EARLY_EXIT_EN to leave RUN once remaining b bits are zero.
module bit_clmul_multi #(
   parameter int XLEN = 32,
   parameter int STEP = 1
) (
   input logic             clk,
   input logic             rst,
   bit_clmul_multi_if.slave bus
);
   localparam int N  = XLEN / STEP;
   localparam int CW = $clog2(N);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]        state;
   logic [CW-1:0]     cnt;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] a_sh;
   logic [XLEN-1:0]   b_sh;
   logic [1:0]        op_q;
   logic [2*XLEN-1:0] partial;
   logic [XLEN-1:0]   slice;
   logic              last;
   logic              run_end;

   // a_sh and b_sh advance by STEP so only the low STEP bits of b matter.
   always_comb begin
      partial = acc;
      for (int j = 0; j < STEP; j++) begin
         if (b_sh[j]) partial = partial ^ (a_sh << j);
      end
      last = (cnt == CW'(N - 1));
`ifdef BIT_CLMUL_EARLY_EXIT_EN
      run_end = last || ((b_sh >> STEP) == '0);
`else
      run_end = last;
`endif
   end

   always_comb begin
      unique case (op_q)
         2'b01:   slice = acc[2*XLEN-1:XLEN];
         2'b10:   slice = acc[2*XLEN-2:XLEN-1];
         default: slice = acc[XLEN-1:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         acc        <= '0;
         a_sh       <= '0;
         b_sh       <= '0;
         op_q       <= 2'b00;
         bus.result <= '0;
         bus.ready  <= 1'b0;
         bus.busy   <= 1'b0;
      end else if (bus.clear) begin
         state     <= IDLE;
         cnt       <= '0;
         acc       <= '0;
         bus.ready <= 1'b0;
         bus.busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.ready <= 1'b0;
               if (bus.enable && bus.op != 2'b11) begin
                  a_sh     <= {{XLEN{1'b0}}, bus.rdata1};
                  b_sh     <= bus.rdata2;
                  op_q     <= bus.op;
                  acc      <= '0;
                  cnt      <= '0;
                  state    <= RUN;
                  bus.busy <= 1'b1;
               end
            end
            RUN: begin
               acc  <= partial;
               a_sh <= a_sh << STEP;
               b_sh <= b_sh >> STEP;
               if (run_end) state <= DONE;
               else         cnt   <= cnt + CW'(1);
            end
            DONE: begin
               bus.result <= slice;
               bus.ready  <= 1'b1;
               bus.busy   <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bit_clmul_multi.sv
// Directed and random bench for bit_clmul_multi at three configurations.
module tb_bit_clmul_multi;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   bit_clmul_multi_if #(.XLEN(32)) ia ();
   bit_clmul_multi_if #(.XLEN(64)) ib ();
   bit_clmul_multi_if #(.XLEN(32)) ic ();

   bit_clmul_multi #(.XLEN(32), .STEP(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   bit_clmul_multi #(.XLEN(64), .STEP(4)) dut_b (.clk(clk), .rst(rst), .bus(ib));
   bit_clmul_multi #(.XLEN(32), .STEP(2)) dut_c (.clk(clk), .rst(rst), .bus(ic));

`ifdef BIT_CLMUL_EARLY_EXIT_EN
   localparam int LAT1 = 4;
   localparam int LAT3 = 3;
`else
   localparam int LAT1 = 34;
   localparam int LAT3 = 18;
`endif

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] o, input int xl);
      logic [127:0] p;
      logic [63:0]  m;
      p = '0;
      for (int i = 0; i < xl; i++)
         if (b[i]) p = p ^ ({64'b0, a} << i);
      if (o == 2'b01) p = p >> xl;
      else if (o == 2'b10) p = p >> (xl - 1);
      m = (xl == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
      return p[63:0] & m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_a(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      ia.op = o; ia.rdata1 = a; ia.rdata2 = b; ia.enable = 1'b1;
      tick();
      ia.enable = 1'b0;
   endtask

   task automatic wait_a(output logic [31:0] r, output int cyc, output int bb);
      cyc = 1; bb = 0;
      while (ia.ready !== 1'b1 && cyc < 300) begin
         if (ia.busy !== 1'b1) bb++;
         tick();
         cyc++;
      end
      chk("a_ready_seen", {63'b0, ia.ready}, 64'd1);
      r = ia.result;
   endtask

   task automatic run_a(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r);
      int cyc, bb;
      start_a(o, a, b);
      wait_a(r, cyc, bb);
   endtask

   task automatic run_b(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] r, output int cyc);
      ib.op = o; ib.rdata1 = a; ib.rdata2 = b; ib.enable = 1'b1;
      tick();
      ib.enable = 1'b0;
      cyc = 1;
      while (ib.ready !== 1'b1 && cyc < 300) begin tick(); cyc++; end
      chk("b_ready_seen", {63'b0, ib.ready}, 64'd1);
      r = ib.result;
   endtask

   task automatic run_c(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r);
      int cyc;
      ic.op = o; ic.rdata1 = a; ic.rdata2 = b; ic.enable = 1'b1;
      tick();
      ic.enable = 1'b0;
      cyc = 1;
      while (ic.ready !== 1'b1 && cyc < 300) begin tick(); cyc++; end
      if (cyc >= 300) chk("c_timeout", 64'd1, 64'd0);
      r = ic.result;
   endtask

   initial begin
      logic [31:0] r;
      logic [63:0] r64;
      logic [31:0] ra, rb;
      logic [1:0]  ro;
      int cyc, bb, cnt;

      ia.enable = 0; ia.op = 0; ia.rdata1 = 0; ia.rdata2 = 0; ia.clear = 0;
      ib.enable = 0; ib.op = 0; ib.rdata1 = 0; ib.rdata2 = 0; ib.clear = 0;
      ic.enable = 0; ic.op = 0; ic.rdata1 = 0; ic.rdata2 = 0; ic.clear = 0;
      rst = 1'b0;
      tick(); tick();
      chk("rst_result", {32'b0, ia.result}, 64'd0);
      chk("rst_ready", {63'b0, ia.ready}, 64'd0);
      chk("rst_busy", {63'b0, ia.busy}, 64'd0);
      chk("rst_b_result", ib.result, 64'd0);
      rst = 1'b1;
      tick();

      // clmul 3*3 with latency, busy and single-pulse checks
      start_a(2'b00, 32'h3, 32'h3);
      wait_a(r, cyc, bb);
      chk("t1_result", {32'b0, r}, 64'h5);
      chk("t1_latency", 64'(cyc), 64'(LAT1));
      chk("t1_busy_gap", 64'(bb), 64'd0);
      chk("t1_busy_after", {63'b0, ia.busy}, 64'd0);
      tick();
      chk("t1_single_pulse", {63'b0, ia.ready}, 64'd0);

      // flush in RUN cycle 10
      start_a(2'b00, 32'h12345678, 32'hFFFFFFFF);
      repeat (9) tick();
      ia.clear = 1'b1;
      tick();
      ia.clear = 1'b0;
      chk("flush_busy", {63'b0, ia.busy}, 64'd0);
      chk("flush_ready", {63'b0, ia.ready}, 64'd0);
      chk("flush_result", {32'b0, ia.result}, 64'h5);
      cnt = 0;
      repeat (40) begin tick(); if (ia.ready === 1'b1) cnt++; end
      chk("flush_no_ready", 64'(cnt), 64'd0);
      run_a(2'b00, 32'h6, 32'h5, r);
      chk("flush_fresh", {32'b0, r}, 64'h1E);

      // top-bit operands for all three ops
      run_a(2'b01, 32'h80000000, 32'h80000000, r);
      chk("t2_clmulh", {32'b0, r}, 64'h40000000);
      run_a(2'b10, 32'h80000000, 32'h80000000, r);
      chk("t2_clmulr", {32'b0, r}, 64'h80000000);
      run_a(2'b00, 32'h80000000, 32'h80000000, r);
      chk("t2_clmul", {32'b0, r}, 64'h0);

      // reserved op never starts
      ia.op = 2'b11; ia.rdata1 = 32'h7; ia.rdata2 = 32'h7; ia.enable = 1'b1;
      cnt = 0;
      repeat (5) begin tick(); if (ia.busy === 1'b1 || ia.ready === 1'b1) cnt++; end
      ia.enable = 1'b0;
      repeat (3) begin tick(); if (ia.busy === 1'b1 || ia.ready === 1'b1) cnt++; end
      chk("rsvd_idle", 64'(cnt), 64'd0);

      // enable with new operands mid-RUN is ignored
      start_a(2'b00, 32'h3, 32'h7);
      repeat (5) tick();
      ia.op = 2'b01; ia.rdata1 = 32'hFF; ia.rdata2 = 32'hFF; ia.enable = 1'b1;
      tick();
      ia.enable = 1'b0;
      wait_a(r, cyc, bb);
      chk("midrun_ignore", {32'b0, r}, 64'h9);
      tick();

      // reset in the middle of RUN
      start_a(2'b00, 32'h3, 32'h3);
      repeat (5) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("mrst_result", {32'b0, ia.result}, 64'd0);
      chk("mrst_ready", {63'b0, ia.ready}, 64'd0);
      chk("mrst_busy", {63'b0, ia.busy}, 64'd0);
      tick();

      // XLEN=64, STEP=4
      run_b(2'b00, 64'hFFFFFFFFFFFFFFFF, 64'h1, r64, cyc);
      chk("t3_result", r64, 64'hFFFFFFFFFFFFFFFF);
      chk("t3_latency", 64'(cyc), 64'(LAT3));
      tick();
      run_b(2'b01, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, r64, cyc);
      chk("t3_clmulh", r64, 64'h7FFFFFFFFFFFFFFF);
      tick();

      // XLEN=32, STEP=2 random ops against the reference model
      for (int k = 0; k < 1000; k++) begin
         ra = $urandom;
         rb = (k % 10 == 0) ? 32'(k) : $urandom;
         ro = 2'($urandom_range(0, 2));
         run_c(ro, ra, rb, r);
         chk("rand_c", {32'b0, r}, model({32'b0, ra}, {32'b0, rb}, ro, 32));
         tick();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/bit_clmul_multi.md
Name: bit_clmul_multi

Overview:
Parametrised multi-cycle carry-less multiplier for the bit-manipulation unit. It supports clmul, clmulh and clmulr at configurable XLEN and processes STEP multiplier bits per cycle. It replaces the fixed 32-bit, one-bit-per-cycle unit beside the ALU in the execute stage. It adds a flush input, a busy flag and a reserved-op check.

Parameters:
XLEN, 32, operand/result width; legal values 32 or 64
STEP, 1, multiplier bits consumed per cycle; must be a power of two that divides XLEN (1,2,4,8)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-low
enable  input  1  start request; sampled only in IDLE
op  input  2  00 clmul, 01 clmulh, 10 clmulr, 11 reserved
rdata1  input  XLEN  multiplicand a
rdata2  input  XLEN  multiplier b
clear  input  1  flush; aborts the operation in flight
busy  output  1  high while in RUN or DONE
ready  output  1  one-cycle pulse; result valid
result  output  XLEN  registered result; holds until the next accept, clear or reset

Behaviour:
- Reset (rst=0 at posedge clk):
  - state IDLE, counter 0, accumulator 0
  - result 0, ready 0, busy 0
  - all outputs are registered.
- Full product: p[2*XLEN-1:0] = XOR over i of (a << i) for every i where b[i]=1.
  - clmul = p[XLEN-1:0]
  - clmulh = p[2*XLEN-1:XLEN]
  - clmulr = p[2*XLEN-2:XLEN-1]
- Accumulator is 2*XLEN bits wide. The final result slice is selected by the latched op.
- IDLE:
  - ready=0.
  - If enable=1 and op!=11: latch a, b and op; clear accumulator and counter; go to RUN.
  - If op=11: no start; stay in IDLE.
- RUN:
  - Each cycle XOR in (a << (counter*STEP+j)) for every j in 0..STEP-1 where b[counter*STEP+j]=1.
  - Then counter+1.
  - After the cycle with counter = XLEN/STEP-1, go to DONE.
  - Counter width is clog2(XLEN/STEP) bits, with no wrap beyond the final value.
- DONE:
  - result <= selected slice; ready=1 for exactly one cycle; go to IDLE.
  - In this cycle, enable is not accepted. A new accept is possible on the following edge.
- Latency: if enable is sampled at edge E, ready=1 during the cycle after edge E+XLEN/STEP+1.
  - Back-to-back throughput is one op every XLEN/STEP+2 cycles.
- enable while busy: ignored; latched operands are unaffected by input changes.
- clear=1 (any state):
  - next state IDLE; ready 0; accumulator 0; result keeps its previous value.
  - clear has priority over enable in the same cycle; no accept occurs.
- rst has priority over clear.

Optional Feature:
Macro BIT_CLMUL_EARLY_EXIT_EN.
- When defined, RUN also goes to DONE after any cycle where all not-yet-processed bits of b are zero.
  - Example: b=0x1, STEP=1 reaches DONE after 1 RUN cycle.
  - b=0 also spends exactly 1 RUN cycle.
- Results are identical to the non-early-exit build; only latency shrinks.
- When undefined, latency is always the fixed value above.

Test Plan:
- XLEN=32, STEP=1: clmul a=0x00000003, b=0x00000003 -> result 0x00000005; ready pulses exactly once, 34 cycles after the accept edge; busy high in between.
- XLEN=32, STEP=1: a=0x80000000, b=0x80000000 -> clmulh 0x40000000, clmulr 0x80000000, clmul 0x00000000.
- XLEN=64, STEP=4: clmul a=0xFFFFFFFFFFFFFFFF, b=0x1 -> result 0xFFFFFFFFFFFFFFFF; ready after 18 cycles (fixed build) or 3 cycles (EARLY_EXIT_EN build).
- Flush: start clmul a=0x12345678, b=0xFFFFFFFF, assert clear at RUN cycle 10 -> busy=0 next cycle, no ready pulse, result unchanged; a fresh op then completes correctly.
- Protocol: op=11 with enable=1 -> busy stays 0, no ready. enable pulsed with new operands mid-RUN -> ignored; result matches the first op.
- Reset mid-RUN (rst=0 one cycle) -> result 0, ready 0, busy 0 next cycle. Compare 1000 random XLEN=32, STEP=2 ops against a software carry-less multiply model.
